instr_sequencer: RTL

- Eight-phase control state machine for the 8-bit RISC CPU; the counterpart that drives the program counter's `Opcode`, `addr`, `SKZ_cmp`, `En_cpu_in` and `Load_in` inputs.
- Fetches each instruction byte from program memory at the current PC and latches it into an instruction register.
- Sequences the operand read, accumulator load and store phases.
- Grants exactly one PC-advance pulse per instruction, and handles halt and program-load mode.

---
 rtl/cpu_pkg.sv | 32 +++
 rtl/instr_sequencer.sv | 115 +++++++++++
 2 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode encodings and the sequencer state set.
// The PC and the ALU decode from the same opcode constants.
package cpu_pkg;

  localparam logic [2:0] OP_HLT = 3'd0;
  localparam logic [2:0] OP_SKZ = 3'd1;
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_AND = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_LDA = 3'd5;
  localparam logic [2:0] OP_STO = 3'd6;
  localparam logic [2:0] OP_JMP = 3'd7;

  typedef enum logic [3:0] {
    ST_INST_ADDR,
    ST_INST_FETCH,
    ST_DECODE,
    ST_OP_ADDR,
    ST_OP_FETCH,
    ST_EXEC,
    ST_STORE,
    ST_UPDATE,
    ST_HALTED,
    ST_LOAD
  } state_e;

  // Instructions that read a memory operand into the accumulator path.
  function automatic logic is_operand(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_AND) || (op == OP_XOR) || (op == OP_LDA);
  endfunction

endpackage

// File: rtl/instr_sequencer.sv
// Eight-phase fetch/decode/execute sequencer for the 8-bit RISC CPU.
// Owns the instruction register and the registered skip-on-zero flag.
module instr_sequencer
  import cpu_pkg::*;
#(
  parameter int DW = 8,
  parameter int AW = 5
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          load_req,
  input  logic [AW-1:0] pc_value,
  input  logic [DW-1:0] mem_rdata,
  input  logic          acc_zero,
  output logic [AW-1:0] mem_addr,
  output logic          mem_rd,
  output logic          mem_wr,
  output logic          data_oe,
  output logic          acc_ld,
  output logic [2:0]    ir_opcode,
  output logic [AW-1:0] ir_addr,
  output logic          skz_cmp,
  output logic          pc_en,
  output logic          pc_load,
  output logic          halted
);

  state_e        state_q, state_d;
  logic [DW-1:0] ir_q, ir_d;
  logic          skz_q, skz_d;
  logic          opnd, sto;

  assign ir_opcode = ir_q[DW-1 -: 3];
  assign ir_addr   = ir_q[AW-1:0];
  assign skz_cmp   = skz_q;
  assign opnd      = is_operand(ir_opcode);
  assign sto       = (ir_opcode == OP_STO);

  // Loader takeover beats the normal flow; IR and skip flag hold while loading.
  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    skz_d   = skz_q;
    if (load_req) begin
      state_d = ST_LOAD;
    end else begin
      unique case (state_q)
        ST_INST_ADDR:  state_d = ST_INST_FETCH;
        ST_INST_FETCH: begin
          state_d = ST_DECODE;
          ir_d    = mem_rdata;
        end
        ST_DECODE: begin
          state_d = ST_OP_ADDR;
          skz_d   = (ir_opcode == OP_SKZ) && acc_zero;
        end
        ST_OP_ADDR:    state_d = ST_OP_FETCH;
        ST_OP_FETCH:   state_d = ST_EXEC;
        ST_EXEC:       state_d = ST_STORE;
        ST_STORE:      state_d = ST_UPDATE;
        ST_UPDATE:     state_d = (ir_opcode == OP_HLT) ? ST_HALTED : ST_INST_ADDR;
        ST_HALTED:     state_d = ST_HALTED;
        ST_LOAD:       state_d = ST_INST_ADDR;
        default:       state_d = ST_INST_ADDR;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_INST_ADDR;
      ir_q    <= '0;
      skz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      skz_q   <= skz_d;
    end
  end

  // Moore outputs: strobes depend only on the state and the latched IR.
  always_comb begin
    mem_addr = pc_value;
    mem_rd   = 1'b0;
    mem_wr   = 1'b0;
    data_oe  = 1'b0;
    acc_ld   = 1'b0;
    pc_en    = 1'b0;
    pc_load  = 1'b0;
    halted   = 1'b0;
    unique case (state_q)
      ST_INST_ADDR, ST_INST_FETCH: mem_rd = 1'b1;
      ST_OP_ADDR, ST_OP_FETCH: begin
        mem_addr = ir_addr;
        mem_rd   = opnd;
      end
      ST_EXEC: begin
        mem_addr = ir_addr;
        mem_rd   = opnd;
        acc_ld   = opnd;
        data_oe  = sto;
      end
      ST_STORE: begin
        mem_addr = ir_addr;
        mem_wr   = sto;
        data_oe  = sto;
      end
      ST_UPDATE: pc_en   = (ir_opcode != OP_HLT);
      ST_HALTED: halted  = 1'b1;
      ST_LOAD:   pc_load = 1'b1;
      default: ;
    endcase
  end

endmodule
